// File: rtl/pc_seq_if.sv
// PC sequencer bus: retire-update handshake, external redirect and PC status.
interface pc_seq_if #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 32
);
   logic              upd_valid;
   logic              upd_ready;
   logic              branch_taken;
   logic [ADDR_W-1:0] target;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_prev;
   logic              halted;
   logic              fault;
   logic [CNT_W-1:0]  retire_cnt;

   // Control unit / debug side
   modport master (
      output upd_valid, branch_taken, target, redirect_valid, redirect_pc,
      input  upd_ready, pc, pc_prev, halted, fault, retire_cnt
   );

   // Sequencer side
   modport slave (
      input  upd_valid, branch_taken, target, redirect_valid, redirect_pc,
      output upd_ready, pc, pc_prev, halted, fault, retire_cnt
   );
endinterface

// File: rtl/pc_seq.sv
// SUBLEQ program-counter sequencer: steps by INSTR_BYTES, branches on taken
// results, halts on a self-loop, faults on misaligned targets, and counts
// retired instructions with a saturating counter.
module pc_seq #(
   parameter int              ADDR_W      = 64,
   parameter int              INSTR_BYTES = 24,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int              CNT_W       = 32
) (
   input  logic     clk,
   input  logic     rst,
   pc_seq_if.slave  bus
);
   typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

   // Stride at full address width so the remainder is taken on the whole
   // address, never on a truncated copy.
   localparam logic [ADDR_W-1:0] L_STRIDE = ADDR_W'(INSTR_BYTES);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [ADDR_W-1:0] r_pc_prev, w_prev_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

   logic w_ready, w_fire, w_tgt_aligned, w_rpc_aligned, w_cnt_max;

   assign w_ready       = (r_state == S_RUN) && !bus.redirect_valid;
   assign w_fire        = bus.upd_valid && w_ready;
   assign w_tgt_aligned = (bus.target % L_STRIDE) == '0;
   assign w_rpc_aligned = (bus.redirect_pc % L_STRIDE) == '0;
   assign w_cnt_max     = &r_cnt;

   // Next state: redirect wins over everything; otherwise only an accepted
   // update moves pc, pc_prev and the retire counter.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_prev_nxt  = r_pc_prev;
      w_cnt_nxt   = r_cnt;
      if (bus.redirect_valid) begin
         w_pc_nxt    = bus.redirect_pc;
         w_state_nxt = w_rpc_aligned ? S_RUN : S_FAULT;
      end else if (w_fire) begin
         w_prev_nxt = r_pc;
         w_cnt_nxt  = w_cnt_max ? r_cnt : r_cnt + CNT_W'(1);
         if (!bus.branch_taken) begin
            // Wraps silently at the top of the address space.
            w_pc_nxt = r_pc + L_STRIDE;
         end else if (bus.target == r_pc) begin
            // Branch-to-self is the program's halt idiom.
            w_state_nxt = S_HALT;
         end else if (!w_tgt_aligned) begin
            w_state_nxt = S_FAULT;
         end else begin
            w_pc_nxt = bus.target;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_RUN;
         r_pc      <= RESET_PC;
         r_pc_prev <= RESET_PC;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_pc_prev <= w_prev_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign bus.upd_ready  = w_ready;
   assign bus.pc         = r_pc;
   assign bus.pc_prev    = r_pc_prev;
   assign bus.retire_cnt = r_cnt;
   assign bus.halted     = (r_state == S_HALT);
   assign bus.fault      = (r_state == S_FAULT);
endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Parameters
REQ-001 SHALL have parameter ADDR_W, default 64, PC and address width in bits.
REQ-002 SHALL have parameter INSTR_BYTES, default 24, instruction stride in bytes; legal range is 1..255.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded at reset; it is a multiple of INSTR_BYTES.
REQ-004 SHALL have parameter CNT_W, default 32, retire counter width.

Interface
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port upd_valid, input, 1: the control unit requests a PC update for the retiring instruction.
REQ-008 SHALL have port upd_ready, output, 1: the sequencer accepts an update this cycle.
REQ-009 SHALL have port branch_taken, input, 1: the retiring SUBLEQ result was <= 0, so branch to target.
REQ-010 SHALL have port target, input, ADDR_W: the branch target (operand C).
REQ-011 SHALL have port redirect_valid, input, 1: external PC load (debug/restart).
REQ-012 SHALL have port redirect_pc, input, ADDR_W: the external load value.
REQ-013 SHALL have port pc, output, ADDR_W: the registered current PC.
REQ-014 SHALL have port pc_prev, output, ADDR_W: the PC of the last retired instruction.
REQ-015 SHALL have port halted, output, 1: the FSM is in HALT.
REQ-016 SHALL have port fault, output, 1: the FSM is in FAULT (misaligned target).
REQ-017 SHALL have port retire_cnt, output, CNT_W: count of accepted updates, saturating.

Function
REQ-018 SHALL implement FSM states RUN, HALT and FAULT; halted = (state==HALT); fault = (state==FAULT).
REQ-019 SHALL drive upd_ready = (state==RUN) && !redirect_valid, combinationally.
REQ-020 SHALL perform an update only on the handshake upd_valid && upd_ready; it takes effect on the next rising edge (1-cycle latency), and pc holds in all other cycles.
REQ-021 On a not-taken update, SHALL set pc <= (pc + INSTR_BYTES) mod 2^ADDR_W, so the PC wraps silently at the top of the address space.
REQ-022 On a taken update with target == pc (self-loop halt convention), SHALL leave pc unchanged and go to HALT.
REQ-023 On a taken update with target mod INSTR_BYTES != 0, SHALL leave pc unchanged and go to FAULT.
REQ-024 On any other taken update, SHALL set pc <= target and stay in RUN.
REQ-025 On every accepted update, including ones that lead to HALT or FAULT, SHALL set pc_prev <= pc and retire_cnt <= retire_cnt + 1, saturating at 2^CNT_W - 1.
REQ-026 SHALL give redirect_valid priority over everything in any state: pc <= redirect_pc and pc_prev, retire_cnt are unchanged.
REQ-027 On a redirect, state SHALL become RUN if redirect_pc mod INSTR_BYTES == 0, else FAULT.
REQ-028 A simultaneous upd_valid during a redirect SHALL NOT be accepted (upd_ready is low), and the requester SHALL hold it.
REQ-029 In HALT and FAULT, SHALL keep upd_ready low and hold pc; only a redirect or reset leaves these states.
REQ-030 The alignment check SHALL be a constant-divisor remainder on the full ADDR_W value; it SHALL NOT truncate the address.

Reset
REQ-031 While rst is low, SHALL asynchronously force pc = RESET_PC, pc_prev = RESET_PC, retire_cnt = 0 and state = RUN (halted = 0, fault = 0).
REQ-032 Reset asserted mid-handshake SHALL discard the update, with no partial pc or counter change.
REQ-033 After rst deasserts, SHALL accept an update on the first clock edge if upd_valid is high.

Verification
REQ-034 Sequential stepping: from reset, 3 not-taken updates -> pc = 0, 24, 48, 72 on successive edges; pc_prev = 48; retire_cnt = 3.
REQ-035 Branch and halt: at pc = 72, taken with target = 240 -> pc = 240; then taken with target = 240 -> halted = 1, pc = 240, upd_ready = 0; later upd_valid pulses leave retire_cnt unchanged.
REQ-036 Misaligned target: taken with target = 100 -> fault = 1, pc unchanged; then redirect_pc = 48 -> RUN, pc = 48, fault = 0.
REQ-037 Wrap-around: with ADDR_W = 8, INSTR_BYTES = 24 and pc = 240, a not-taken update -> pc = 8.
REQ-038 Priority: redirect_valid and upd_valid in the same cycle -> pc = redirect_pc, retire_cnt unchanged; the held update is accepted on the next cycle.
REQ-039 Saturation and reset: with CNT_W = 2, 5 updates -> retire_cnt = 3; async rst mid-cycle -> all outputs at reset values before the next edge.
